memr_sweep_controller: RTL

//   Sequences one read-modify-write sweep over a contiguous row range of the R residual

---
 rtl/memr_sweep_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/memr_sweep_controller.sv
// rtl/memr_sweep_controller.sv - one-row-in-flight read/update/write-back sweep over memR rows
module memr_sweep_controller #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int address_width = 20
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [address_width-1:0]               row_base,
    input  logic [address_width-1:0]               row_count,
    output logic                                   busy,
    output logic                                   finish,
    output logic [address_width-1:0]               mem_read_address,
    input  logic [element_width*no_of_units-1:0]   memory_output,
    output logic                                   mem_write_enable,
    output logic [address_width-1:0]               mem_write_address,
    output logic [element_width*no_of_units-1:0]   mem_input_data,
    output logic                                   op_valid,
    input  logic                                   op_ready,
    output logic [element_width*no_of_units-1:0]   op_data,
    output logic [address_width-1:0]               op_row,
    input  logic                                   res_valid,
    output logic                                   res_ready,
    input  logic [element_width*no_of_units-1:0]   res_data
);

    localparam int W = element_width * no_of_units;
    localparam logic [address_width-1:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OFFER,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [address_width-1:0] base_q, base_d;
    logic [address_width-1:0] count_q, count_d;
    logic [address_width-1:0] idx_q, idx_d;
    logic [address_width-1:0] rd_addr_q, rd_addr_d;
    logic [address_width-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0]             op_data_q, op_data_d;
    logic [W-1:0]             wr_data_q, wr_data_d;
    logic [address_width-1:0] idx_next;

    assign idx_next = idx_q + IDX_ONE;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        op_data_d = op_data_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = row_base;
                    count_d   = row_count;
                    idx_d     = '0;
                    rd_addr_d = row_base;
                    state_d   = (row_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                op_data_d = memory_output;
                wr_addr_d = rd_addr_q;
                state_d   = S_OFFER;
            end
            S_OFFER: begin
                if (op_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    wr_data_d = res_data;
                    // Move the read port to the next row so it never aliases the row being written.
                    rd_addr_d = base_q + idx_next;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d   = idx_next;
                state_d = (idx_next == count_q) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            op_data_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            op_data_q <= op_data_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign finish            = (state_q == S_DONE);
    assign mem_write_enable  = (state_q == S_WRITE);
    assign op_valid          = (state_q == S_OFFER);
    assign res_ready         = (state_q == S_WAIT);
    assign mem_read_address  = rd_addr_q;
    assign mem_write_address = wr_addr_q;
    assign mem_input_data    = wr_data_q;
    assign op_data           = op_data_q;
    assign op_row            = idx_q;

endmodule
